alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Execution-side consumer of the 4-bit ALU control code produced by the ALU controller.
- Performs the selected operation on two WIDTH-bit operands under a start/done handshake.
- Logic and arithmetic ops complete in one cycle; unsigned multiply and divide are iterative (one bit per cycle).
- Sits in the EX stage of the multi-cycle CPU variant; the controller stalls on busy_o.

Parameters:
WIDTH, 32, operand/result width (≥4)
CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous active-low reset
start_i  input  1  request; sampled only in IDLE
ALUCtrl_i  input  4  operation code, captured with start_i
src1_i  input  WIDTH  operand A (dividend/multiplicand), captured with start_i
src2_i  input  WIDTH  operand B (divisor/multiplier), captured with start_i
result_o  output  WIDTH  low result / quotient
hi_o  output  WIDTH  product upper half / remainder; 0 for other ops
zero_o  output  1  result_o == 0
busy_o  output  1  high in RUN
done_o  output  1  one-cycle completion pulse
err_o  output  1  invalid code or divide-by-zero; valid with done_o, held until next completion

Behaviour:
- One clock, clk_i. Reset is synchronous and active-low on rst_i.
- Reset: rst_i low at a rising edge sets state IDLE, counter 0, and all outputs 0 (zero_o = 1 since result_o = 0).
  - Reset overrides an operation in progress with no partial result.
- Codes:
  - 0000 AND; 0001 OR; 0010 ADD (wraps mod 2^WIDTH); 0110 SUB (wraps).
  - 0111 SLT: signed compare; result 1 or 0.
  - 1100 NOR.
  - 1000 MULU: unsigned, 2·WIDTH-bit product; hi_o = upper half, result_o = lower half.
  - 1001 DIVU: unsigned restoring divide; result_o = quotient, hi_o = remainder.
  - Any other code, including 1111: invalid.
- States: IDLE, RUN, FIN.
- IDLE:
  - start_i low: stay.
  - start_i high: capture the code and operands.
  - Single-cycle code: at the same edge E0, write result_o and hi_o = 0; go to FIN.
  - Invalid code: result_o = 0, hi_o = 0, err_o = 1; go to FIN.
  - DIVU with src2_i = 0: result_o = all ones, hi_o = src1_i, err_o = 1; go to FIN (no iteration).
  - MULU, or DIVU with nonzero divisor: load counter = WIDTH, clear accumulators; go to RUN.
- RUN:
  - busy_o = 1. Each edge performs one shift-add (MULU) or one shift-subtract-restore (DIVU) step and decrements the counter.
  - The edge that decrements the counter to 0 writes the final result_o and hi_o and goes to FIN.
  - Total: WIDTH edges in RUN (E1..E_WIDTH).
- FIN: done_o = 1 for exactly this one cycle; next edge goes to IDLE. done_o is registered, high only in FIN.
- Latency, start edge to done_o high:
  - Single-cycle, invalid, and div-by-zero ops: 1 cycle.
  - MULU and nonzero DIVU: WIDTH+1 cycles.
- err_o is cleared on any valid completion.
- Ignored starts: start_i in RUN or FIN has no effect and is not queued. Back-to-back ops therefore need start_i re-asserted in the IDLE cycle after FIN; minimum issue interval is 2 cycles.
- Output hold: result_o, hi_o and zero_o hold their last completed values through IDLE and RUN.
  - Intermediate accumulators are internal and never visible on the outputs.
- Operand stability: operand changes after the capture edge have no effect.

Test Plan:
- Reset then idle: hold rst_i low for 2 edges, release -> result_o = 0, hi_o = 0, zero_o = 1, busy_o = 0, done_o = 0, err_o = 0.
- Single-cycle ops, start each from IDLE:
  - ADD 0xFFFFFFFF + 1 -> done after 1 cycle, result_o = 0, zero_o = 1.
  - SUB 5 − 7 -> 0xFFFFFFFE.
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - NOR 0 vs 0 -> 0xFFFFFFFF.
- MULU 0xFFFFFFFF × 0xFFFFFFFF:
  - busy_o high exactly 32 cycles; done_o pulses at cycle 33.
  - hi_o = 0xFFFFFFFE, result_o = 0x00000001.
- DIVU 100 ÷ 7 -> result_o = 14, hi_o = 2, err_o = 0, 33-cycle latency.
- DIVU 100 ÷ 0 -> done after 1 cycle, result_o = 0xFFFFFFFF, hi_o = 100, err_o = 1.
- Code 1111 -> err_o = 1 with done, result_o = 0.
- start_i held high during MULU RUN -> no restart and exactly one done_o.
- rst_i low at RUN cycle 10 -> IDLE next cycle, all outputs 0, no done_o.

Source files
------------

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: EX-stage ALU with a start/done handshake.
//   Logic and arithmetic ops finish in one cycle. Unsigned multiply (shift-add) and
//   unsigned divide (restoring) take one bit per cycle.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   start_i      request, sampled only in IDLE
//   ALUCtrl_i    4-bit operation code, captured with start_i
//   src1_i       operand A (dividend / multiplicand)
//   src2_i       operand B (divisor / multiplier)
//   result_o     low result / quotient
//   hi_o         product upper half / remainder, 0 for other ops
//   zero_o       result_o == 0
//   busy_o       high while iterating
//   done_o       one-cycle completion pulse
//   err_o        invalid code or divide-by-zero, held until next completion
module alu_seq_exec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpNor  = 4'b1100;
  localparam logic [3:0] OpMulu = 4'b1000;
  localparam logic [3:0] OpDivu = 4'b1001;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;  // product high / partial remainder
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;  // multiplier shifting out / dividend -> quotient
  logic [WIDTH-1:0]  opb_q, opb_d;        // multiplicand or divisor
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic              err_q, err_d;

  // One multiply step: conditionally add, then shift the {carry, hi, lo} pair right.
  logic [WIDTH:0]    mul_sum;
  // One divide step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]    div_shift;
  logic              div_ge;
  logic [WIDTH-1:0]  div_diff;
  logic [WIDTH-1:0]  step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    // True difference is below the divisor, so WIDTH bits are enough.
    div_diff  = div_shift[WIDTH-1:0] - opb_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    hi_d     = hi_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StFin;
          hi_d    = '0;
          err_d   = 1'b0;
          case (ALUCtrl_i)
            OpAnd: result_d = src1_i & src2_i;
            OpOr:  result_d = src1_i | src2_i;
            OpAdd: result_d = src1_i + src2_i;
            OpSub: result_d = src1_i - src2_i;
            OpSlt: result_d = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OpNor: result_d = ~(src1_i | src2_i);
            OpMulu: begin
              state_d  = StRun;
              cnt_d    = CNT_W'(WIDTH);
              is_div_d = 1'b0;
              acc_hi_d = '0;
              acc_lo_d = src2_i;
              opb_d    = src1_i;
            end
            OpDivu: begin
              if (src2_i == '0) begin
                result_d = '1;
                hi_d     = src1_i;
                err_d    = 1'b1;
              end else begin
                state_d  = StRun;
                cnt_d    = CNT_W'(WIDTH);
                is_div_d = 1'b1;
                acc_hi_d = '0;
                acc_lo_d = src1_i;
                opb_d    = src2_i;
              end
            end
            default: begin
              result_d = '0;
              err_d    = 1'b1;
            end
          endcase
        end
      end
      StRun: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = StFin;
          result_d = step_lo;
          hi_d     = step_hi;
          err_d    = 1'b0;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      err_q    <= err_d;
    end
  end

  assign result_o = result_q;
  assign hi_o     = hi_q;
  assign zero_o   = (result_q == '0);
  assign busy_o   = (state_q == StRun);
  assign done_o   = (state_q == StFin);
  assign err_o    = err_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctrl = 4'h0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [31:0] result, hi;
  logic        zero, busy, done, err;

  int tests = 0;
  int failed = 0;
  int lat, bcnt, dcnt;

  alu_seq_exec #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ALUCtrl_i(ctrl),
    .src1_i(src1), .src2_i(src2), .result_o(result), .hi_o(hi),
    .zero_o(zero), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE and run until done_o (bounded). Operands are scrambled
  // after the capture edge. hold keeps start_i high until done is seen.
  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int l, output int bc, output int dc);
    @(negedge clk);
    ctrl = code; src1 = a; src2 = b; start = 1'b1;
    l = 0; bc = 0; dc = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
      src1 = ~a; src2 = ~b; ctrl = ~code;
      l++;
      if (busy) bc++;
      if (done) begin
        dc++;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("rst_result", result, 0);
    check("rst_hi", hi, 0);
    check("rst_zero", zero, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    run_op(4'b0010, 32'hFFFF_FFFF, 32'h1, 0, lat, bcnt, dcnt);
    check("add_lat", lat, 1);
    check("add_result", result, 0);
    check("add_zero", zero, 1);
    check("add_hi", hi, 0);

    run_op(4'b0110, 32'd5, 32'd7, 0, lat, bcnt, dcnt);
    check("sub_result", result, 32'hFFFF_FFFE);
    check("sub_zero", zero, 0);

    run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, 0, lat, bcnt, dcnt);
    check("slt_result", result, 1);
    run_op(4'b0111, 32'h1, 32'hFFFF_FFFF, 0, lat, bcnt, dcnt);
    check("slt_false", result, 0);

    run_op(4'b1100, 32'h0, 32'h0, 0, lat, bcnt, dcnt);
    check("nor_result", result, 32'hFFFF_FFFF);
    run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, lat, bcnt, dcnt);
    check("and_result", result, 32'h00F0_1234);
    run_op(4'b0001, 32'hF000_0001, 32'h0000_1000, 0, lat, bcnt, dcnt);
    check("or_result", result, 32'hF000_1001);

    run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bcnt, dcnt);
    check("mul_busy_cycles", bcnt, 32);
    check("mul_lat", lat, 33);
    check("mul_done", dcnt, 1);
    check("mul_hi", hi, 32'hFFFF_FFFE);
    check("mul_lo", result, 32'h0000_0001);
    check("mul_err", err, 0);

    run_op(4'b1000, 32'h0001_0003, 32'h0002_0005, 0, lat, bcnt, dcnt);
    check("mul2_pair", {hi, result}, 64'h0000_0002_000B_000F);

    run_op(4'b1001, 32'd100, 32'd7, 0, lat, bcnt, dcnt);
    check("div_lat", lat, 33);
    check("div_quo", result, 14);
    check("div_rem", hi, 2);
    check("div_err", err, 0);

    run_op(4'b1001, 32'hFFFF_FFFF, 32'h10, 0, lat, bcnt, dcnt);
    check("div2_pair", {hi, result}, 64'h0000_000F_0FFF_FFFF);

    run_op(4'b1001, 32'd100, 32'd0, 0, lat, bcnt, dcnt);
    check("div0_lat", lat, 1);
    check("div0_quo", result, 32'hFFFF_FFFF);
    check("div0_rem", hi, 100);
    check("div0_err", err, 1);

    // err_o held through IDLE, then cleared by a valid completion
    @(negedge clk);
    check("err_hold", err, 1);
    run_op(4'b1111, 32'h1234, 32'h5678, 0, lat, bcnt, dcnt);
    check("inv_lat", lat, 1);
    check("inv_err", err, 1);
    check("inv_result", result, 0);
    check("inv_hi", hi, 0);
    run_op(4'b0010, 32'd3, 32'd4, 0, lat, bcnt, dcnt);
    check("err_clear", err, 0);
    check("add2_result", result, 7);

    // start held high through RUN: no restart, one done
    run_op(4'b1000, 32'd3, 32'd5, 1, lat, bcnt, dcnt);
    check("hold_lat", lat, 33);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("hold_extra_done", dcnt, 0);
    check("hold_result", result, 15);

    // Reset at RUN cycle 10
    @(negedge clk);
    ctrl = 4'b1000; src1 = 32'd9; src2 = 32'd9; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", busy, 1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pair", {hi, result}, 0);
    check("mid_rst_zero", zero, 1);
    check("mid_rst_err", err, 0);
    rst = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("post_rst_quiet", dcnt, 0);
    run_op(4'b0110, 32'd10, 32'd3, 0, lat, bcnt, dcnt);
    check("post_rst_lat", lat, 1);
    check("post_rst_result", result, 7);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
